// File: rtl/ant_swarm_engine_pkg.sv
// Shared constants, opcodes, FSM encodings and instruction packing helpers for the ant swarm engine.
package ant_swarm_engine_pkg;

   localparam int SCREEN_WIDTH      = 160;
   localparam int SCREEN_HEIGHT     = 120;
   localparam int BLOCK_WIDTH       = 4;
   localparam int BLOCK_HEIGHT      = 4;
   localparam int X_COORD_WIDTH     = 8;
   localparam int Y_COORD_WIDTH     = 7;
   localparam int COLOUR_WIDTH      = 3;
   localparam int MEM_ADDR_WIDTH    = 16;
   localparam int RESULT_WIDTH      = 16;
   localparam int OPCODE_WIDTH      = 4;
   localparam int INSTRUCTION_WIDTH = 40;

   localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP      = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD  = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMWRITE = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW     = 4'h3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_X,
      ST_RD_Y,
      ST_RD_DX,
      ST_RD_DY,
`ifdef ANT_SWARM_ERASE_EN
      ST_ERASE,
`endif
      ST_COMPUTE,
      ST_WR_X,
      ST_WR_Y,
      ST_WR_DX,
      ST_WR_DY,
      ST_DRAW,
      ST_NEXT
   } ant_state_e;

   typedef enum logic [1:0] {
      RQ_IDLE,
      RQ_HOLD,
      RQ_WAIT
   } rq_state_e;

   function automatic logic [INSTRUCTION_WIDTH-1:0] pack_read(input logic [MEM_ADDR_WIDTH-1:0] addr);
      logic [INSTRUCTION_WIDTH-1:0] w;
      w = '0;
      w[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_MEMREAD;
      w[MEM_ADDR_WIDTH-1:0] = addr;
      return w;
   endfunction

   function automatic logic [INSTRUCTION_WIDTH-1:0] pack_write(input logic [MEM_ADDR_WIDTH-1:0] addr,
                                                               input logic [RESULT_WIDTH-1:0] data);
      logic [INSTRUCTION_WIDTH-1:0] w;
      w = '0;
      w[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_MEMWRITE;
      w[MEM_ADDR_WIDTH +: RESULT_WIDTH] = data;
      w[MEM_ADDR_WIDTH-1:0] = addr;
      return w;
   endfunction

   function automatic logic [INSTRUCTION_WIDTH-1:0] pack_draw(input logic [X_COORD_WIDTH-1:0] x,
                                                              input logic [Y_COORD_WIDTH-1:0] y,
                                                              input logic [COLOUR_WIDTH-1:0] colour);
      logic [INSTRUCTION_WIDTH-1:0] w;
      w = '0;
      w[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_DRAW;
      w[X_COORD_WIDTH-1:0] = x;
      w[X_COORD_WIDTH +: Y_COORD_WIDTH] = y;
      w[X_COORD_WIDTH+Y_COORD_WIDTH +: COLOUR_WIDTH] = colour;
      w[X_COORD_WIDTH+Y_COORD_WIDTH+COLOUR_WIDTH] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/ant_swarm_engine_dp_requester.sv
// Runs one datapath transaction: ISSUE (combinational, same cycle as req), HOLD, then WAIT for finished_dp.
module ant_swarm_engine_dp_requester
   import ant_swarm_engine_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         req,
   input  logic [INSTRUCTION_WIDTH-1:0] instr,
   output logic                         done,
   output logic [RESULT_WIDTH-1:0]      data,
   input  logic                         finished_dp,
   input  logic [RESULT_WIDTH-1:0]      result_dp,
   output logic                         start_dp,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

   rq_state_e                    state, state_d;
   logic [INSTRUCTION_WIDTH-1:0] instr_q;
   logic                         issue;

   assign issue = (state == RQ_IDLE) && req;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= RQ_IDLE;
         instr_q <= '0;
      end else begin
         state <= state_d;
         if (issue) instr_q <= instr;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         RQ_IDLE: if (req) state_d = RQ_HOLD;
         RQ_HOLD: state_d = RQ_WAIT;
         RQ_WAIT: if (finished_dp) state_d = RQ_IDLE;
         default: state_d = RQ_IDLE;
      endcase
   end

   // The issued instruction is held in instr_q so it stays stable until the next ISSUE.
   always_comb begin
      start_dp       = issue || (state == RQ_HOLD);
      instruction_dp = issue ? instr : instr_q;
      done           = (state == RQ_WAIT) && finished_dp;
      data           = result_dp;
   end

endmodule

// File: rtl/ant_swarm_engine.sv
// Walks NUM_ANTS ant records: read, optionally move/bounce and write back, then draw each ant.
// Optional ANT_SWARM_ERASE_EN adds a background-colour draw at the old position before the move.
module ant_swarm_engine
   import ant_swarm_engine_pkg::*;
#(
   parameter int                      NUM_ANTS   = 8,
   parameter int                      BASE_ADDR  = 0,
   parameter int                      REC_STRIDE = 4,
   parameter int                      VEL_W      = 4,
   parameter int                      X_MAX      = SCREEN_WIDTH - BLOCK_WIDTH,
   parameter int                      Y_MAX      = SCREEN_HEIGHT - BLOCK_HEIGHT,
   parameter logic [COLOUR_WIDTH-1:0] ANT_COLOUR = 3'b100,
   parameter logic [COLOUR_WIDTH-1:0] BG_COLOUR  = 3'b000
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         update_en,
   output logic                         finished,
   output logic [7:0]                   ant_index,
   input  logic                         finished_dp,
   input  logic [RESULT_WIDTH-1:0]      result_dp,
   output logic                         start_dp,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_dp
);

   localparam int XW = X_COORD_WIDTH + 1;
   localparam int YW = Y_COORD_WIDTH + 1;

   ant_state_e                   state, state_d;
   logic                         upd_q;
   logic [X_COORD_WIDTH-1:0]     x_q, x_new;
   logic [Y_COORD_WIDTH-1:0]     y_q, y_new;
   logic signed [VEL_W-1:0]      dx_q, dy_q, dx_new, dy_new;
   logic signed [XW-1:0]         dxe, nx;
   logic signed [YW-1:0]         dye, ny;
   logic                         x_reflect, y_reflect;
   logic                         req, rq_done;
   logic [INSTRUCTION_WIDTH-1:0] req_instr;
   logic [RESULT_WIDTH-1:0]      rq_data;
   logic [MEM_ADDR_WIDTH-1:0]    rec_base;
   logic                         unused_rd_hi;

   assign rec_base     = MEM_ADDR_WIDTH'(BASE_ADDR) + MEM_ADDR_WIDTH'(REC_STRIDE) * MEM_ADDR_WIDTH'(ant_index);
   assign unused_rd_hi = ^rq_data[RESULT_WIDTH-1:X_COORD_WIDTH];

   // Move one step; on leaving the screen negate velocity and step back by the old velocity.
   assign dxe       = {{(XW-VEL_W){dx_q[VEL_W-1]}}, dx_q};
   assign dye       = {{(YW-VEL_W){dy_q[VEL_W-1]}}, dy_q};
   assign nx        = $signed({1'b0, x_q}) + dxe;
   assign ny        = $signed({1'b0, y_q}) + dye;
   assign x_reflect = nx[XW-1] || (nx > $signed(XW'(X_MAX)));
   assign y_reflect = ny[YW-1] || (ny > $signed(YW'(Y_MAX)));
   assign x_new     = x_reflect ? (x_q - dxe[X_COORD_WIDTH-1:0]) : nx[X_COORD_WIDTH-1:0];
   assign y_new     = y_reflect ? (y_q - dye[Y_COORD_WIDTH-1:0]) : ny[Y_COORD_WIDTH-1:0];
   assign dx_new    = x_reflect ? -dx_q : dx_q;
   assign dy_new    = y_reflect ? -dy_q : dy_q;

   ant_swarm_engine_dp_requester u_dp_requester (
      .clock          (clock),
      .reset          (reset),
      .req            (req),
      .instr          (req_instr),
      .done           (rq_done),
      .data           (rq_data),
      .finished_dp    (finished_dp),
      .result_dp      (result_dp),
      .start_dp       (start_dp),
      .instruction_dp (instruction_dp)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE:    if (start) state_d = ST_RD_X;
         ST_RD_X:    if (rq_done) state_d = ST_RD_Y;
         ST_RD_Y:    if (rq_done) state_d = upd_q ? ST_RD_DX : ST_DRAW;
         ST_RD_DX:   if (rq_done) state_d = ST_RD_DY;
`ifdef ANT_SWARM_ERASE_EN
         ST_RD_DY:   if (rq_done) state_d = ST_ERASE;
         ST_ERASE:   if (rq_done) state_d = ST_COMPUTE;
`else
         ST_RD_DY:   if (rq_done) state_d = ST_COMPUTE;
`endif
         ST_COMPUTE: state_d = ST_WR_X;
         ST_WR_X:    if (rq_done) state_d = ST_WR_Y;
         ST_WR_Y:    if (rq_done) state_d = ST_WR_DX;
         ST_WR_DX:   if (rq_done) state_d = ST_WR_DY;
         ST_WR_DY:   if (rq_done) state_d = ST_DRAW;
         ST_DRAW:    if (rq_done) state_d = ST_NEXT;
         ST_NEXT:    state_d = (ant_index == 8'(NUM_ANTS - 1)) ? ST_IDLE : ST_RD_X;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req       = 1'b1;
      req_instr = '0;
      finished  = 1'b0;
      unique case (state)
         ST_IDLE:    begin req = 1'b0; finished = 1'b1; end
         ST_RD_X:    req_instr = pack_read(rec_base);
         ST_RD_Y:    req_instr = pack_read(rec_base + MEM_ADDR_WIDTH'(1));
         ST_RD_DX:   req_instr = pack_read(rec_base + MEM_ADDR_WIDTH'(2));
         ST_RD_DY:   req_instr = pack_read(rec_base + MEM_ADDR_WIDTH'(3));
`ifdef ANT_SWARM_ERASE_EN
         ST_ERASE:   req_instr = pack_draw(x_q, y_q, BG_COLOUR);
`endif
         ST_WR_X:    req_instr = pack_write(rec_base, RESULT_WIDTH'(x_q));
         ST_WR_Y:    req_instr = pack_write(rec_base + MEM_ADDR_WIDTH'(1), RESULT_WIDTH'(y_q));
         ST_WR_DX:   req_instr = pack_write(rec_base + MEM_ADDR_WIDTH'(2),
                                            {{(RESULT_WIDTH-VEL_W){dx_q[VEL_W-1]}}, dx_q});
         ST_WR_DY:   req_instr = pack_write(rec_base + MEM_ADDR_WIDTH'(3),
                                            {{(RESULT_WIDTH-VEL_W){dy_q[VEL_W-1]}}, dy_q});
         ST_DRAW:    req_instr = pack_draw(x_q, y_q, ANT_COLOUR);
         default:    req = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         upd_q     <= 1'b0;
         ant_index <= '0;
         x_q       <= '0;
         y_q       <= '0;
         dx_q      <= '0;
         dy_q      <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (start) begin
               upd_q     <= update_en;
               ant_index <= '0;
            end
            ST_RD_X:  if (rq_done) x_q  <= rq_data[X_COORD_WIDTH-1:0];
            ST_RD_Y:  if (rq_done) y_q  <= rq_data[Y_COORD_WIDTH-1:0];
            ST_RD_DX: if (rq_done) dx_q <= rq_data[VEL_W-1:0];
            ST_RD_DY: if (rq_done) dy_q <= rq_data[VEL_W-1:0];
            ST_COMPUTE: begin
               x_q  <= x_new;
               y_q  <= y_new;
               dx_q <= dx_new;
               dy_q <= dy_new;
            end
            ST_NEXT: if (ant_index != 8'(NUM_ANTS - 1)) ant_index <= ant_index + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ant_swarm_engine.sv
// Scoreboard bench: expected datapath instructions are queued per pass, a datapath model pops and checks them.
module tb_ant_swarm_engine;

   localparam int IW = 40;
   localparam int RW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          update_en;
   logic          finished;
   logic [7:0]    ant_index;
   logic          finished_dp;
   logic [RW-1:0] result_dp;
   logic          start_dp;
   logic [IW-1:0] instruction_dp;

   always #5 clock = ~clock;

   ant_swarm_engine #(.NUM_ANTS(3)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .update_en      (update_en),
      .finished       (finished),
      .ant_index      (ant_index),
      .finished_dp    (finished_dp),
      .result_dp      (result_dp),
      .start_dp       (start_dp),
      .instruction_dp (instruction_dp)
   );

   logic [IW-1:0] exp_q[$];
   logic [RW-1:0] mem [0:15];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            dp_delay = 0;
   bit            arm_reset   = 1'b0;
   bit            reset_fired = 1'b0;

   // Hand-derived ant table: old state and the state after one move/bounce step.
   int            ox [3] = '{10, 155, 154};
   int            oy [3] = '{20, 1, 1};
   int            nx [3] = '{12, 153, 156};
   int            ny [3] = '{19, 4, 0};
   logic [15:0]   ndx[3] = '{16'h0002, 16'hFFFE, 16'h0002};
   logic [15:0]   ndy[3] = '{16'hFFFF, 16'h0003, 16'hFFFF};

`ifdef ANT_SWARM_ERASE_EN
   localparam int BUSY_UPD = 3 * 32;
`else
   localparam int BUSY_UPD = 3 * 29;
`endif
   localparam int BUSY_DRAW0 = 3 * 10;
   localparam int BUSY_DRAW7 = 3 * 31;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] rd(input int a);
      return {4'h1, 20'h0, 16'(a)};
   endfunction

   function automatic logic [IW-1:0] wr(input int a, input logic [15:0] d);
      return {4'h2, 4'h0, d, 16'(a)};
   endfunction

   function automatic logic [IW-1:0] dr(input int x, input int y, input logic [2:0] c);
      return {4'h3, 17'h0, 1'b1, c, 7'(y), 8'(x)};
   endfunction

   task automatic load_mem();
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      mem[0] = 16'd10;  mem[1] = 16'd20; mem[2]  = 16'h0002; mem[3]  = 16'hFFFF;
      mem[4] = 16'd155; mem[5] = 16'd1;  mem[6]  = 16'h0002; mem[7]  = 16'hFFFD;
      mem[8] = 16'd154; mem[9] = 16'd1;  mem[10] = 16'h0002; mem[11] = 16'hFFFF;
   endtask

   task automatic push_update_pass();
      int b;
      for (int a = 0; a < 3; a++) begin
         b = 4 * a;
         for (int k = 0; k < 4; k++) exp_q.push_back(rd(b + k));
`ifdef ANT_SWARM_ERASE_EN
         exp_q.push_back(dr(ox[a], oy[a], 3'b000));
`endif
         exp_q.push_back(wr(b, 16'(nx[a])));
         exp_q.push_back(wr(b + 1, 16'(ny[a])));
         exp_q.push_back(wr(b + 2, ndx[a]));
         exp_q.push_back(wr(b + 3, ndy[a]));
         exp_q.push_back(dr(nx[a], ny[a], 3'b100));
      end
   endtask

   task automatic push_draw_pass();
      for (int a = 0; a < 3; a++) begin
         exp_q.push_back(rd(4 * a));
         exp_q.push_back(rd(4 * a + 1));
         exp_q.push_back(dr(nx[a], ny[a], 3'b100));
      end
   endtask

   // Datapath model and monitor: checks each issued instruction and the ISSUE/HOLD/WAIT shape.
   initial begin : dp_model
      int            phase;
      int            wcnt;
      logic [IW-1:0] cur;
      bit            bad;
      phase = 0; wcnt = 0; cur = '0; bad = 1'b0;
      finished_dp = 1'b0;
      result_dp   = '0;
      forever begin
         @(negedge clock);
         finished_dp = 1'b0;
         if (reset) begin
            phase = 0;
            continue;
         end
         case (phase)
            0: if (start_dp) begin
               cur = instruction_dp;
               bad = 1'b0;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_txn: got %0h expected none", cur);
               end else begin
                  check("instr", cur, exp_q.pop_front());
               end
               if (arm_reset && cur[39:36] == 4'h2 && cur[15:0] == 16'd5) begin
                  reset       = 1'b1;
                  arm_reset   = 1'b0;
                  reset_fired = 1'b1;
                  exp_q.delete();
                  phase = 0;
               end else begin
                  phase = 1;
               end
            end
            1: begin
               if (!start_dp || instruction_dp !== cur) bad = 1'b1;
               wcnt  = 0;
               phase = 2;
            end
            default: begin
               if (start_dp || instruction_dp !== cur) bad = 1'b1;
               if (wcnt == dp_delay) begin
                  finished_dp = 1'b1;
                  if (cur[39:36] == 4'h1) result_dp = mem[cur[3:0]];
                  else if (cur[39:36] == 4'h2) mem[cur[3:0]] = cur[31:16];
                  check("handshake_shape", {63'd0, bad}, 64'd0);
                  phase = 0;
               end else begin
                  wcnt++;
               end
            end
         endcase
      end
   end

   task automatic run_pass(input bit upd, input int delay, input int exp_busy, input string tag);
      int busy;
      busy = 0;
      dp_delay = delay;
      @(negedge clock);
      start = 1'b1;
      update_en = upd;
      @(negedge clock);
      start = 1'b0;
      update_en = ~upd;
      while (!finished && busy < 5000) begin
         busy++;
         start = (busy == 20);
         @(negedge clock);
      end
      start = 1'b0;
      check({tag, "_busy_cycles"}, 64'(busy), 64'(exp_busy));
      check({tag, "_finished"}, {63'd0, finished}, 64'd1);
      check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int waited;
      reset = 1'b1;
      start = 1'b0;
      update_en = 1'b0;
      load_mem();
      repeat (3) @(negedge clock);
      check("rst_finished", {63'd0, finished}, 64'd1);
      check("rst_start_dp", {63'd0, start_dp}, 64'd0);
      check("rst_instruction_dp", 64'(instruction_dp), 64'd0);
      check("rst_ant_index", 64'(ant_index), 64'd0);
      reset = 1'b0;

      push_update_pass();
      run_pass(1'b1, 0, BUSY_UPD, "update_d0");
      check("ant_index_last", 64'(ant_index), 64'd2);
      check("mem_ant1_x", 64'(mem[4]), 64'd153);
      check("mem_ant1_dx", 64'(mem[6]), 64'hFFFE);

      push_draw_pass();
      run_pass(1'b0, 0, BUSY_DRAW0, "draw_d0");

      push_draw_pass();
      run_pass(1'b0, 7, BUSY_DRAW7, "draw_d7");

      load_mem();
      push_update_pass();
      dp_delay = 0;
      arm_reset = 1'b1;
      @(negedge clock);
      start = 1'b1;
      update_en = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waited = 0;
      while (!reset_fired && waited < 500) begin
         @(posedge clock);
         waited++;
      end
      check("reset_reached_wr_y_ant1", {63'd0, reset_fired}, 64'd1);
      @(negedge clock);
      check("midrst_start_dp", {63'd0, start_dp}, 64'd0);
      check("midrst_finished", {63'd0, finished}, 64'd1);
      check("midrst_ant_index", 64'(ant_index), 64'd0);
      reset = 1'b0;
      reset_fired = 1'b0;
      arm_reset = 1'b0;

      load_mem();
      push_update_pass();
      run_pass(1'b1, 0, BUSY_UPD, "rerun_d0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
